// File: rtl/imem_loader_if.sv
// Host/loader bundle for the instruction-memory loader: byte stream in, IM write port and
// CPU hold/status out. The loader uses the slave modport, the host the master modport.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              Start;
   logic [7:0]        RX_Data;
   logic              RX_Valid;
   logic              RX_Ready;
   logic [ADDR_W-1:0] IM_ADDR;
   logic [15:0]       IM_DATA;
   logic              IM_WR;
   logic              CPU_Hold;
   logic              Busy;
   logic              Done;
   logic              Error;
   logic [ADDR_W:0]   Words_Written;

   modport master (
      output Start, RX_Data, RX_Valid,
      input  RX_Ready, IM_ADDR, IM_DATA, IM_WR, CPU_Hold, Busy, Done, Error, Words_Written
   );

   modport slave (
      input  Start, RX_Data, RX_Valid,
      output RX_Ready, IM_ADDR, IM_DATA, IM_WR, CPU_Hold, Busy, Done, Error, Words_Written
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: parses {count, words, xor checksum} from a byte stream, writes
// words to IM and keeps the CPU held in reset unless the whole load verified.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   imem_loader_if.slave bus
);
   localparam int          NW    = ADDR_W + 1;
   localparam logic [32:0] MAX_N = 33'(1) << ADDR_W;

   typedef enum logic [3:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [7:0]        cnt_hi_q;
   logic [NW-1:0]     n_q;
   logic [7:0]        hi_q;
   logic [7:0]        csum_q;
   logic [NW-1:0]     ww_q;
   logic [ADDR_W-1:0] im_addr_q;
   logic [15:0]       im_data_q;
   logic              im_wr_q;
   logic              hold_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic              rx_ready;
   logic              accept;
   logic [15:0]       count_d;
   logic              count_bad;
   logic [7:0]        csum_d;
   logic [NW-1:0]     ww_d;
   logic              last_word;

   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_CSUM: rx_ready = 1'b1;
         default:                                    rx_ready = 1'b0;
      endcase
   end

   assign accept    = rx_ready & bus.RX_Valid;
   assign count_d   = {cnt_hi_q, bus.RX_Data};
   // Zero-length programs are rejected too: a CPU released onto empty memory is never useful.
   assign count_bad = (count_d == 16'd0) || ({17'd0, count_d} > MAX_N);
   assign csum_d    = csum_q ^ bus.RX_Data;
   assign ww_d      = ww_q + NW'(1);
   assign last_word = (ww_d == n_q);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         cnt_hi_q  <= '0;
         n_q       <= '0;
         hi_q      <= '0;
         csum_q    <= '0;
         ww_q      <= '0;
         im_addr_q <= '0;
         im_data_q <= '0;
         im_wr_q   <= 1'b0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.Start) begin
                  state_q <= S_CNT_HI;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  ww_q    <= '0;
                  csum_q  <= '0;
                  hold_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_CNT_HI: begin
               if (accept) begin
                  cnt_hi_q <= bus.RX_Data;
                  csum_q   <= csum_d;
                  state_q  <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (accept) begin
                  csum_q <= csum_d;
                  if (count_bad) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     n_q     <= NW'(count_d);
                     state_q <= S_W_HI;
                  end
               end
            end
            S_W_HI: begin
               if (accept) begin
                  hi_q    <= bus.RX_Data;
                  csum_q  <= csum_d;
                  state_q <= S_W_LO;
               end
            end
            S_W_LO: begin
               // Write-port registers are loaded here so they are valid exactly during WRITE.
               if (accept) begin
                  csum_q    <= csum_d;
                  im_wr_q   <= 1'b1;
                  im_addr_q <= ww_q[ADDR_W-1:0];
                  im_data_q <= {hi_q, bus.RX_Data};
                  state_q   <= S_WRITE;
               end
            end
            S_WRITE: begin
               im_wr_q <= 1'b0;
               ww_q    <= ww_d;
               state_q <= last_word ? S_CSUM : S_W_HI;
            end
            S_CSUM: begin
               if (accept) begin
                  busy_q <= 1'b0;
                  if (bus.RX_Data == csum_q) begin
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.RX_Ready      = rx_ready;
   assign bus.IM_ADDR       = im_addr_q;
   assign bus.IM_DATA       = im_data_q;
   assign bus.IM_WR         = im_wr_q;
   assign bus.CPU_Hold      = hold_q;
   assign bus.Busy          = busy_q;
   assign bus.Done          = done_q;
   assign bus.Error         = err_q;
   assign bus.Words_Written = ww_q;

   a_done_err_excl: assert property (@(posedge Clock) disable iff (!Reset) !(done_q && err_q));
   a_wr_only_in_write: assert property (@(posedge Clock) disable iff (!Reset)
                                        im_wr_q |-> (state_q == S_WRITE));
   a_done_releases: assert property (@(posedge Clock) disable iff (!Reset) done_q |-> !hold_q);

endmodule
